instruction_fetch_unit: RTL and testbench

Initiator side of the Instruction_Memory read interface. It owns the 64-bit program counter and drives InstructionAddress. It samples the combinational Instruction return and presents {pc, instruction} to decode over a valid/ready handshake. It supports backpressure, taken-branch redirect with flush, and a fault halt on a bad fetch address.

---
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, instruction memory fetch and decode handshake
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] MEM_BYTES = 64'd64,
    parameter logic [63:0] PC_STEP   = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] InstructionAddress,
    input  logic [31:0] Instruction,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic        fault,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [63:0] if_pc_q;
    logic        fault_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            if_pc_q <= 64'd0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    // A redirect outranks both the range check and the capture of the old PC.
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_HALT;
                    end else if (branch_taken) begin
                        pc_q    <= branch_target;
                        valid_q <= 1'b0;
                    end else if (pc_q >= MEM_BYTES) begin
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_HALT;
                    end else if (!valid_q || if_ready) begin
                        instr_q <= Instruction;
                        if_pc_q <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + PC_STEP;
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign InstructionAddress = pc_q;
    assign if_valid           = valid_q;
    assign if_instruction     = instr_q;
    assign if_pc              = if_pc_q;
    assign fault              = fault_q;
    assign halted             = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [63:0] RPC  = 64'd8;
    localparam logic [63:0] MB   = 64'd64;
    localparam logic [63:0] STEP = 64'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] InstructionAddress;
    logic [31:0] Instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        fault;
    logic        halted;

    instruction_fetch_unit #(
        .RESET_PC (RPC),
        .MEM_BYTES(MB),
        .PC_STEP  (STEP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .InstructionAddress(InstructionAddress),
        .Instruction       (Instruction),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .if_valid          (if_valid),
        .if_ready          (if_ready),
        .if_instruction    (if_instruction),
        .if_pc             (if_pc),
        .fault             (fault),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < MB) return mem[a[5:2]];
        return a[31:0] ^ 32'hA5A5_5A5A;
    endfunction

    always_comb Instruction = mem_word(InstructionAddress);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } word_t;

    word_t       exp_q[$];
    word_t       mon_w;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference machine: where fetching is, whether a word awaits decode, and whether it stopped.
    logic [63:0] m_pc;
    bit          m_idle, m_held, m_halt, m_fault;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RPC;
        m_idle = 1'b1;
        m_held = 1'b0;
        m_halt = 1'b0;
        m_fault = 1'b0;
        exp_q.delete();
    endtask

    task automatic stop_fetching();
        if (m_held && !if_ready) void'(exp_q.pop_back());
        m_held = 1'b0;
    endtask

    // Applied at each rising edge using the inputs that were present across that edge.
    task automatic model_step();
        word_t w;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (!m_halt) begin
            if (branch_taken && (branch_target % 4 != 0)) begin
                stop_fetching();
                m_halt = 1'b1;
                m_fault = 1'b1;
            end else if (branch_taken) begin
                stop_fetching();
                m_pc = branch_target;
            end else if (m_pc >= MB) begin
                stop_fetching();
                m_halt = 1'b1;
                m_fault = 1'b1;
            end else if (!m_held || if_ready) begin
                w.pc  = m_pc;
                w.ins = mem_word(m_pc);
                exp_q.push_back(w);
                m_held = 1'b1;
                m_pc   = m_pc + STEP;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("if_valid", 64'(if_valid), 64'(m_held));
            chk("InstructionAddress", InstructionAddress, m_pc);
            chk("fault", 64'(fault), 64'(m_fault));
            chk("halted", 64'(halted), 64'(m_halt));
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL transfer: got if_pc 0x%0h with no word expected at %0t", if_pc, $time);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("if_pc", if_pc, mon_w.pc);
                    chk("if_instruction", 64'(if_instruction), 64'(mon_w.ins));
                end
            end
        end
    end

    task automatic drive(input int ep);
        int r;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
        if (ep == 0) begin
            if_ready = 1'b1;
        end else if (ep == 1) begin
            if_ready = ($urandom % 3) != 0;
        end else begin
            if_ready = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) begin
                branch_taken = 1'b1;
                r = $urandom % 20;
                if (r == 0 && ep >= 4)
                    branch_target = 64'(($urandom % 16) * 4 + ($urandom % 3) + 1);
                else if (r == 1)
                    branch_target = MB;
                else
                    branch_target = 64'(($urandom % 16) * 4);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        reset         = 1'b0;
        if_ready      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_pc", if_pc, 64'd0);
        chk("reset if_instruction", 64'(if_instruction), 64'd0);
        chk("reset InstructionAddress", InstructionAddress, RPC);
        chk("reset if_valid", 64'(if_valid), 64'd0);

        for (int ep = 0; ep < 8; ep++) begin
            reset = 1'b1;
            for (int c = 0; c < 120; c++) begin
                @(posedge clk);
                model_step();
                #1;
                drive(ep);
            end
            // Reset dropped between edges must clear outputs without waiting for the clock.
            #2;
            reset = 1'b0;
            #1;
            chk("async if_valid", 64'(if_valid), 64'd0);
            chk("async InstructionAddress", InstructionAddress, RPC);
            chk("async fault", 64'(fault), 64'd0);
            chk("async halted", 64'(halted), 64'd0);
            chk("async if_pc", if_pc, 64'd0);
            model_reset();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
